ctrl_resolve: RTL and testbench
===============================

CTRL_RESOLVE -- requirements
Module: ctrl_resolve

Interface
- REQ-001 SHALL have parameter ID_W, default `SIZE_ACTIVELIST_LOG+1: active-list ID width; MSB is the wrap bit used for age comparison.
- REQ-002 clk  in  1  single clock, all state on rising edge.
- REQ-003 reset_n  in  1  asynchronous, active-low reset.
- REQ-004 valid_i  in  1  control-ALU result valid this cycle.
- REQ-005 result_i, nextPC_i, pc_i  in  `SIZE_PC each  link/CSR read value, resolved target, instruction PC.
- REQ-006 direction_i  in  1;  flags_i  in  exeFlgs  resolved direction and execute flags (mispredict, isControl, isPredicted, destValid).
- REQ-007 csrWrEn_i  in  1;  csrWrAddr_i  in  `CSR_WIDTH_LOG;  csrWrData_i  in  `CSR_WIDTH  speculative CSR write request.
- REQ-008 alID_i  in  ID_W  active-list ID of the executing instruction.
- REQ-009 flush_i  in  1  pipeline recovery, kills all speculative state.
- REQ-010 commitValid_i  in  1;  commitAlID_i  in  ID_W  head-of-active-list instruction committing.
- REQ-011 wbValid_o  out  1;  wbResult_o  out  `SIZE_PC;  wbAlID_o  out  ID_W;  wbFlags_o  out  exeFlgs  registered writeback packet.
- REQ-012 redirectValid_o  out  1;  redirectPC_o  out  `SIZE_PC;  redirectAlID_o  out  ID_W;  redirectAck_i  in  1  fetch redirect valid/ack handshake.
- REQ-013 bpUpdValid_o  out  1;  bpUpdPC_o, bpUpdTarget_o  out  `SIZE_PC;  bpUpdDir_o  out  1  predictor update.
- REQ-014 csrWrEn_o  out  1;  csrWrAddr_o  out  `CSR_WIDTH_LOG;  csrWrData_o  out  `CSR_WIDTH  non-speculative CSR file write.
- REQ-015 stall_o  out  1  combinational; issue must not send a CSR-writing op.

Function
- REQ-016 Writeback packet SHALL be a one-cycle register of the inputs; wbValid_o = valid_i delayed 1 cycle, forced 0 on cycle after flush_i.
- REQ-017 bpUpd* SHALL be registered 1 cycle, asserted for valid_i with flags_i.isControl=1; bpUpdTarget_o = nextPC_i.
- REQ-018 Redirect holder SHALL be one entry: EMPTY/HELD; EMPTY->HELD on valid_i & mispredict; HELD->EMPTY on redirectAck_i or flush_i.
- REQ-019 In HELD, a new mispredict SHALL replace the entry only if older: IDs differ in wrap bit -> larger low bits is older; same wrap bit -> smaller low bits is older.
- REQ-020 Ack and an older mispredict in the same cycle SHALL leave HELD with the new entry; redirect outputs stable while valid and unacked.
- REQ-021 CSR buffer FSM SHALL be IDLE/PENDING: IDLE->PENDING on valid_i & csrWrEn_i, capturing addr/data/alID.
- REQ-022 PENDING->IDLE when commitValid_i & commitAlID_i == buffered ID; csrWrEn_o pulses 1 cycle after, with buffered addr/data.
- REQ-023 stall_o SHALL be 1 whenever state is PENDING; a CSR write arriving in PENDING is a protocol error (assertion), input ignored.
- REQ-024 flush_i SHALL discard PENDING (no CSR write) unless the same cycle commits the buffered ID; commit wins.
- REQ-025 Latency: valid_i -> wb/bp/redirect outputs exactly 1 cycle; commit -> csrWrEn_o exactly 1 cycle.

Reset
- REQ-026 While reset_n=0, all outputs SHALL be 0, redirect holder EMPTY, CSR FSM IDLE, asynchronously; reset mid-PENDING drops the write.

Configuration
- REQ-027 CTRL_RESOLVE_PERF_EN defined: 32-bit saturating ports perfBranch_o (isPredicted resolves) and perfMispred_o (mispredicts), cleared by reset, unaffected by flush.
- REQ-028 Undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
- REQ-029 exeFlgs, ID_W-based age-compare function, CSR FSM state enum SHALL live in the shared package.
- REQ-030 One sub-module ctrl_csr_buf (CSR FSM) is natural; redirect and writeback logic stays in the top.

Verification
- REQ-031 BEQ pc=0x100, mispredict, alID=0x05 -> next cycle redirectValid_o=1, redirectPC_o=nextPC_i; held until ack.
- REQ-032 HELD alID=0x05, new mispredict alID=0x03 -> replaced; then alID=0x07 -> not replaced; wrap case held 0x3E, new 0x41 (wrap bit differs) -> not replaced.
- REQ-033 CSRRW addr 0x001 data 0xA5, alID 0x10 -> stall_o=1; commit 0x10 -> csrWrEn_o 1 cycle, addr 0x001 data 0xA5, stall_o=0.
- REQ-034 PENDING then flush_i without commit -> no csrWrEn_o, IDLE; flush with same-cycle commit -> write occurs.
- REQ-035 reset_n low during HELD+PENDING -> all outputs 0 immediately, no write after release.
- REQ-036 PERF_EN: 3 branches, 1 mispredict -> perfBranch_o=3, perfMispred_o=1.

Source files
------------

// File: rtl/ctrl_resolve_pkg.sv
// ctrl_resolve_pkg: shared widths, execute-flag struct, FSM state enums and
// the active-list age comparison used by the control-resolve block.
// Optional feature macro used by ctrl_resolve: CTRL_RESOLVE_PERF_EN.

`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 6
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef CSR_WIDTH_LOG
`define CSR_WIDTH_LOG 12
`endif
`ifndef CSR_WIDTH
`define CSR_WIDTH 32
`endif

package ctrl_resolve_pkg;

  // Active-list ID carries one extra MSB that toggles on every wrap of the list.
  localparam int ID_W_DEFAULT = `SIZE_ACTIVELIST_LOG + 1;
  localparam int PC_W         = `SIZE_PC;
  localparam int CSR_AW       = `CSR_WIDTH_LOG;
  localparam int CSR_DW       = `CSR_WIDTH;

  typedef struct packed {
    logic mispredict;
    logic isControl;
    logic isPredicted;
    logic destValid;
  } exeFlgs;

  typedef enum logic {
    REDIR_EMPTY,
    REDIR_HELD
  } redir_state_e;

  typedef enum logic {
    CSR_IDLE,
    CSR_PENDING
  } csr_state_e;

  // Returns 1 when ID a is strictly older than ID b for a w-bit ID.
  // Different wrap bits: the list has wrapped between them, so the larger
  // index is the older one. Same wrap bit: the smaller index is older.
  function automatic logic id_is_older(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input int          w);
    logic [31:0] mask;
    logic [31:0] low_a;
    logic [31:0] low_b;
    logic        wrap_a;
    logic        wrap_b;
    mask   = (32'd1 << (w - 1)) - 32'd1;
    low_a  = a & mask;
    low_b  = b & mask;
    wrap_a = (((a >> (w - 1)) & 32'd1) != 32'd0);
    wrap_b = (((b >> (w - 1)) & 32'd1) != 32'd0);
    if (wrap_a != wrap_b) begin
      return (low_a > low_b);
    end
    return (low_a < low_b);
  endfunction

endpackage

// File: rtl/ctrl_resolve_if.sv
// ctrl_resolve_if: execute-result, commit, writeback, redirect, predictor
// update and CSR-write signals of the control-resolve block. The block itself
// connects through the slave modport; the pipeline side uses master.

interface ctrl_resolve_if #(
  parameter int ID_W = ctrl_resolve_pkg::ID_W_DEFAULT
) ();
  import ctrl_resolve_pkg::*;

  // execute side
  logic              valid_i;
  logic [PC_W-1:0]   result_i;
  logic [PC_W-1:0]   nextPC_i;
  logic [PC_W-1:0]   pc_i;
  logic              direction_i;
  exeFlgs            flags_i;
  logic              csrWrEn_i;
  logic [CSR_AW-1:0] csrWrAddr_i;
  logic [CSR_DW-1:0] csrWrData_i;
  logic [ID_W-1:0]   alID_i;
  logic              flush_i;
  logic              commitValid_i;
  logic [ID_W-1:0]   commitAlID_i;

  // writeback packet
  logic              wbValid_o;
  logic [PC_W-1:0]   wbResult_o;
  logic [ID_W-1:0]   wbAlID_o;
  exeFlgs            wbFlags_o;

  // fetch redirect
  logic              redirectValid_o;
  logic [PC_W-1:0]   redirectPC_o;
  logic [ID_W-1:0]   redirectAlID_o;
  logic              redirectAck_i;

  // branch predictor update
  logic              bpUpdValid_o;
  logic [PC_W-1:0]   bpUpdPC_o;
  logic [PC_W-1:0]   bpUpdTarget_o;
  logic              bpUpdDir_o;

  // committed CSR write and issue stall
  logic              csrWrEn_o;
  logic [CSR_AW-1:0] csrWrAddr_o;
  logic [CSR_DW-1:0] csrWrData_o;
  logic              stall_o;

  modport slave (
    input  valid_i, result_i, nextPC_i, pc_i, direction_i, flags_i,
           csrWrEn_i, csrWrAddr_i, csrWrData_i, alID_i, flush_i,
           commitValid_i, commitAlID_i, redirectAck_i,
    output wbValid_o, wbResult_o, wbAlID_o, wbFlags_o,
           redirectValid_o, redirectPC_o, redirectAlID_o,
           bpUpdValid_o, bpUpdPC_o, bpUpdTarget_o, bpUpdDir_o,
           csrWrEn_o, csrWrAddr_o, csrWrData_o, stall_o
  );

  modport master (
    output valid_i, result_i, nextPC_i, pc_i, direction_i, flags_i,
           csrWrEn_i, csrWrAddr_i, csrWrData_i, alID_i, flush_i,
           commitValid_i, commitAlID_i, redirectAck_i,
    input  wbValid_o, wbResult_o, wbAlID_o, wbFlags_o,
           redirectValid_o, redirectPC_o, redirectAlID_o,
           bpUpdValid_o, bpUpdPC_o, bpUpdTarget_o, bpUpdDir_o,
           csrWrEn_o, csrWrAddr_o, csrWrData_o, stall_o
  );

endinterface

// File: rtl/ctrl_csr_buf.sv
// ctrl_csr_buf: single-entry buffer that holds a speculative CSR write until
// its instruction commits, then releases it as a one-cycle write pulse.
// Issue is stalled for the whole time an entry is buffered.

module ctrl_csr_buf
  import ctrl_resolve_pkg::*;
#(
  parameter int ID_W = ID_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  input  logic              i_csr_wr_en,
  input  logic [CSR_AW-1:0] i_csr_addr,
  input  logic [CSR_DW-1:0] i_csr_data,
  input  logic [ID_W-1:0]   i_al_id,
  input  logic              i_flush,
  input  logic              i_commit_valid,
  input  logic [ID_W-1:0]   i_commit_al_id,
  output logic              o_csr_wr_en,
  output logic [CSR_AW-1:0] o_csr_addr,
  output logic [CSR_DW-1:0] o_csr_data,
  output logic              o_stall
);

  csr_state_e        r_state;
  csr_state_e        w_state_next;
  logic              w_capture;
  logic              w_fire;
  logic              w_commit_hit;
  logic [CSR_AW-1:0] r_addr;
  logic [CSR_DW-1:0] r_data;
  logic [ID_W-1:0]   r_id;
  logic              r_wr_en;

  // Next state: capture a new write when idle; release on commit, which
  // takes priority over a same-cycle flush.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_fire       = 1'b0;
    w_commit_hit = i_commit_valid && (i_commit_al_id == r_id);
    case (r_state)
      CSR_IDLE: begin
        if (i_valid && i_csr_wr_en && !i_flush) begin
          w_state_next = CSR_PENDING;
          w_capture    = 1'b1;
        end
      end
      CSR_PENDING: begin
        if (w_commit_hit) begin
          w_state_next = CSR_IDLE;
          w_fire       = 1'b1;
        end else if (i_flush) begin
          w_state_next = CSR_IDLE;
        end
      end
      default: w_state_next = CSR_IDLE;
    endcase
  end

  // State, buffered request and the registered write pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CSR_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_id    <= '0;
      r_wr_en <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wr_en <= w_fire;
      if (w_capture) begin
        r_addr <= i_csr_addr;
        r_data <= i_csr_data;
        r_id   <= i_al_id;
      end
    end
  end

  // The buffer cannot be overwritten before the pulse, because a new capture
  // only lands at the end of the pulse cycle.
  assign o_csr_wr_en = r_wr_en;
  assign o_csr_addr  = r_addr;
  assign o_csr_data  = r_data;
  assign o_stall     = (r_state == CSR_PENDING);

  // Issue must honour the stall: no CSR-writing op while one is buffered.
  a_no_csr_write_while_pending: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(r_state == CSR_PENDING && i_valid && i_csr_wr_en)
  );

endmodule

// File: rtl/ctrl_resolve.sv
// ctrl_resolve: control-ALU result stage. Registers the writeback packet and
// predictor update, holds the oldest outstanding mispredict redirect until
// fetch acknowledges it, and defers CSR writes to commit via ctrl_csr_buf.
// Define CTRL_RESOLVE_PERF_EN to add saturating branch/mispredict counters.

module ctrl_resolve
  import ctrl_resolve_pkg::*;
#(
  parameter int ID_W = ID_W_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  ctrl_resolve_if.slave bus
`ifdef CTRL_RESOLVE_PERF_EN
  ,
  output logic [31:0] perfBranch_o,
  output logic [31:0] perfMispred_o
`endif
);

  logic            w_mispredict;
  logic            w_new_older;

  logic            r_wb_valid;
  logic [PC_W-1:0] r_wb_result;
  logic [ID_W-1:0] r_wb_id;
  exeFlgs          r_wb_flags;

  logic            r_bp_valid;
  logic [PC_W-1:0] r_bp_pc;
  logic [PC_W-1:0] r_bp_target;
  logic            r_bp_dir;

  redir_state_e    r_redir_state;
  redir_state_e    w_redir_state_next;
  logic            w_redir_load;
  logic [PC_W-1:0] r_redir_pc;
  logic [ID_W-1:0] r_redir_id;

  assign w_mispredict = bus.valid_i && bus.flags_i.mispredict;
  assign w_new_older  = id_is_older(32'(bus.alID_i), 32'(r_redir_id), ID_W);

  // Writeback packet: straight one-cycle copy, valid suppressed by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_valid  <= 1'b0;
      r_wb_result <= '0;
      r_wb_id     <= '0;
      r_wb_flags  <= '0;
    end else begin
      r_wb_valid  <= bus.valid_i && !bus.flush_i;
      r_wb_result <= bus.result_i;
      r_wb_id     <= bus.alID_i;
      r_wb_flags  <= bus.flags_i;
    end
  end

  // Predictor update for every resolved control instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bp_valid  <= 1'b0;
      r_bp_pc     <= '0;
      r_bp_target <= '0;
      r_bp_dir    <= 1'b0;
    end else begin
      r_bp_valid  <= bus.valid_i && bus.flags_i.isControl;
      r_bp_pc     <= bus.pc_i;
      r_bp_target <= bus.nextPC_i;
      r_bp_dir    <= bus.direction_i;
    end
  end

  // Redirect holder next state. A mispredict younger than the held one is on
  // the wrong path of the held redirect and is dropped, even when the held
  // entry is acked in the same cycle; an older one always takes the slot.
  always_comb begin
    w_redir_state_next = r_redir_state;
    w_redir_load       = 1'b0;
    if (bus.flush_i) begin
      w_redir_state_next = REDIR_EMPTY;
    end else begin
      case (r_redir_state)
        REDIR_EMPTY: begin
          if (w_mispredict) begin
            w_redir_state_next = REDIR_HELD;
            w_redir_load       = 1'b1;
          end
        end
        REDIR_HELD: begin
          if (w_mispredict && w_new_older) begin
            w_redir_load = 1'b1;
          end else if (bus.redirectAck_i) begin
            w_redir_state_next = REDIR_EMPTY;
          end
        end
        default: w_redir_state_next = REDIR_EMPTY;
      endcase
    end
  end

  // Redirect holder state and payload; payload only changes on a load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_redir_state <= REDIR_EMPTY;
      r_redir_pc    <= '0;
      r_redir_id    <= '0;
    end else begin
      r_redir_state <= w_redir_state_next;
      if (w_redir_load) begin
        r_redir_pc <= bus.nextPC_i;
        r_redir_id <= bus.alID_i;
      end
    end
  end

  assign bus.wbValid_o       = r_wb_valid;
  assign bus.wbResult_o      = r_wb_result;
  assign bus.wbAlID_o        = r_wb_id;
  assign bus.wbFlags_o       = r_wb_flags;
  assign bus.bpUpdValid_o    = r_bp_valid;
  assign bus.bpUpdPC_o       = r_bp_pc;
  assign bus.bpUpdTarget_o   = r_bp_target;
  assign bus.bpUpdDir_o      = r_bp_dir;
  assign bus.redirectValid_o = (r_redir_state == REDIR_HELD);
  assign bus.redirectPC_o    = r_redir_pc;
  assign bus.redirectAlID_o  = r_redir_id;

  ctrl_csr_buf #(
    .ID_W(ID_W)
  ) u_csr_buf (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_valid        (bus.valid_i),
    .i_csr_wr_en    (bus.csrWrEn_i),
    .i_csr_addr     (bus.csrWrAddr_i),
    .i_csr_data     (bus.csrWrData_i),
    .i_al_id        (bus.alID_i),
    .i_flush        (bus.flush_i),
    .i_commit_valid (bus.commitValid_i),
    .i_commit_al_id (bus.commitAlID_i),
    .o_csr_wr_en    (bus.csrWrEn_o),
    .o_csr_addr     (bus.csrWrAddr_o),
    .o_csr_data     (bus.csrWrData_o),
    .o_stall        (bus.stall_o)
  );

`ifdef CTRL_RESOLVE_PERF_EN
  logic [31:0] r_perf_branch;
  logic [31:0] r_perf_mispred;

  // Saturating event counters; flush does not undo an observed resolve.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_branch  <= '0;
      r_perf_mispred <= '0;
    end else begin
      if (bus.valid_i && bus.flags_i.isPredicted && (r_perf_branch != 32'hFFFF_FFFF)) begin
        r_perf_branch <= r_perf_branch + 32'd1;
      end
      if (w_mispredict && (r_perf_mispred != 32'hFFFF_FFFF)) begin
        r_perf_mispred <= r_perf_mispred + 32'd1;
      end
    end
  end

  assign perfBranch_o  = r_perf_branch;
  assign perfMispred_o = r_perf_mispred;
`endif

endmodule

// File: tb/tb_ctrl_resolve.sv
// tb_ctrl_resolve: directed self-checking bench for ctrl_resolve.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_ctrl_resolve;
  import ctrl_resolve_pkg::*;

  localparam int ID_W = ID_W_DEFAULT;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  ctrl_resolve_if #(.ID_W(ID_W)) ifc ();

`ifdef CTRL_RESOLVE_PERF_EN
  logic [31:0] perf_branch;
  logic [31:0] perf_mispred;
`endif

  ctrl_resolve #(.ID_W(ID_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
`ifdef CTRL_RESOLVE_PERF_EN
    ,
    .perfBranch_o  (perf_branch),
    .perfMispred_o (perf_mispred)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.valid_i       = 1'b0;
    ifc.result_i      = '0;
    ifc.nextPC_i      = '0;
    ifc.pc_i          = '0;
    ifc.direction_i   = 1'b0;
    ifc.flags_i       = '0;
    ifc.csrWrEn_i     = 1'b0;
    ifc.csrWrAddr_i   = '0;
    ifc.csrWrData_i   = '0;
    ifc.alID_i        = '0;
    ifc.flush_i       = 1'b0;
    ifc.commitValid_i = 1'b0;
    ifc.commitAlID_i  = '0;
    ifc.redirectAck_i = 1'b0;
  endtask

  task automatic exe(input logic mp, input logic ctl, input logic prd,
                     input logic [ID_W-1:0] id, input logic [PC_W-1:0] pc,
                     input logic [PC_W-1:0] npc);
    ifc.valid_i             = 1'b1;
    ifc.flags_i.mispredict  = mp;
    ifc.flags_i.isControl   = ctl;
    ifc.flags_i.isPredicted = prd;
    ifc.flags_i.destValid   = 1'b0;
    ifc.alID_i              = id;
    ifc.pc_i                = pc;
    ifc.nextPC_i            = npc;
    ifc.direction_i         = 1'b1;
    ifc.result_i            = pc + 32'd4;
  endtask

  task automatic csr_req(input logic [CSR_AW-1:0] addr, input logic [CSR_DW-1:0] data,
                         input logic [ID_W-1:0] id);
    ifc.valid_i     = 1'b1;
    ifc.csrWrEn_i   = 1'b1;
    ifc.csrWrAddr_i = addr;
    ifc.csrWrData_i = data;
    ifc.alID_i      = id;
  endtask

  task automatic test_reset();
    $display("txn reset: hold reset_n low");
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ifc.wbValid_o !== 1'b0) begin failures++; $display("FAIL reset_wbValid got=%0h exp=0", ifc.wbValid_o); end
    checks++; if (ifc.redirectValid_o !== 1'b0) begin failures++; $display("FAIL reset_redirectValid got=%0h exp=0", ifc.redirectValid_o); end
    checks++; if (ifc.bpUpdValid_o !== 1'b0) begin failures++; $display("FAIL reset_bpUpdValid got=%0h exp=0", ifc.bpUpdValid_o); end
    checks++; if (ifc.csrWrEn_o !== 1'b0) begin failures++; $display("FAIL reset_csrWrEn got=%0h exp=0", ifc.csrWrEn_o); end
    checks++; if (ifc.stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", ifc.stall_o); end
    checks++; if (ifc.wbResult_o !== '0) begin failures++; $display("FAIL reset_wbResult got=%0h exp=0", ifc.wbResult_o); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_writeback();
    $display("txn writeback: alu result id=0x02 result=0x1234");
    exe(1'b0, 1'b0, 1'b0, 7'h02, 32'h50, 32'h54);
    ifc.result_i          = 32'h1234;
    ifc.flags_i.destValid = 1'b1;
    tick(); clear_inputs();
    checks++; if (ifc.wbValid_o !== 1'b1) begin failures++; $display("FAIL wb_valid got=%0h exp=1", ifc.wbValid_o); end
    checks++; if (ifc.wbResult_o !== 32'h1234) begin failures++; $display("FAIL wb_result got=%0h exp=1234", ifc.wbResult_o); end
    checks++; if (ifc.wbAlID_o !== 7'h02) begin failures++; $display("FAIL wb_alid got=%0h exp=02", ifc.wbAlID_o); end
    checks++; if (ifc.wbFlags_o !== 4'b0001) begin failures++; $display("FAIL wb_flags got=%0h exp=1", ifc.wbFlags_o); end
    checks++; if (ifc.bpUpdValid_o !== 1'b0) begin failures++; $display("FAIL bp_nonctl got=%0h exp=0", ifc.bpUpdValid_o); end

    $display("txn writeback: branch pc=0x200 target=0x240 taken");
    exe(1'b0, 1'b1, 1'b1, 7'h03, 32'h200, 32'h240);
    tick(); clear_inputs();
    checks++; if (ifc.bpUpdValid_o !== 1'b1) begin failures++; $display("FAIL bp_valid got=%0h exp=1", ifc.bpUpdValid_o); end
    checks++; if (ifc.bpUpdPC_o !== 32'h200) begin failures++; $display("FAIL bp_pc got=%0h exp=200", ifc.bpUpdPC_o); end
    checks++; if (ifc.bpUpdTarget_o !== 32'h240) begin failures++; $display("FAIL bp_target got=%0h exp=240", ifc.bpUpdTarget_o); end
    checks++; if (ifc.bpUpdDir_o !== 1'b1) begin failures++; $display("FAIL bp_dir got=%0h exp=1", ifc.bpUpdDir_o); end
    checks++; if (ifc.redirectValid_o !== 1'b0) begin failures++; $display("FAIL bp_no_redirect got=%0h exp=0", ifc.redirectValid_o); end

    tick();
    checks++; if (ifc.wbValid_o !== 1'b0) begin failures++; $display("FAIL wb_idle got=%0h exp=0", ifc.wbValid_o); end
    checks++; if (ifc.bpUpdValid_o !== 1'b0) begin failures++; $display("FAIL bp_idle got=%0h exp=0", ifc.bpUpdValid_o); end

    $display("txn writeback: result with same-cycle flush");
    exe(1'b0, 1'b0, 1'b0, 7'h04, 32'h60, 32'h64);
    ifc.flush_i = 1'b1;
    tick(); clear_inputs();
    checks++; if (ifc.wbValid_o !== 1'b0) begin failures++; $display("FAIL wb_flush got=%0h exp=0", ifc.wbValid_o); end
  endtask

  task automatic test_redirect();
    $display("txn redirect: BEQ pc=0x100 mispredict id=0x05 target=0x180");
    exe(1'b1, 1'b1, 1'b1, 7'h05, 32'h100, 32'h180);
    tick(); clear_inputs();
    checks++; if (ifc.redirectValid_o !== 1'b1) begin failures++; $display("FAIL redir_valid got=%0h exp=1", ifc.redirectValid_o); end
    checks++; if (ifc.redirectPC_o !== 32'h180) begin failures++; $display("FAIL redir_pc got=%0h exp=180", ifc.redirectPC_o); end
    checks++; if (ifc.redirectAlID_o !== 7'h05) begin failures++; $display("FAIL redir_id got=%0h exp=05", ifc.redirectAlID_o); end
    repeat (2) tick();
    checks++; if (ifc.redirectValid_o !== 1'b1) begin failures++; $display("FAIL redir_hold_valid got=%0h exp=1", ifc.redirectValid_o); end
    checks++; if (ifc.redirectPC_o !== 32'h180) begin failures++; $display("FAIL redir_hold_pc got=%0h exp=180", ifc.redirectPC_o); end

    $display("txn redirect: older mispredict id=0x03 target=0x300");
    exe(1'b1, 1'b1, 1'b1, 7'h03, 32'h0F0, 32'h300);
    tick(); clear_inputs();
    checks++; if (ifc.redirectAlID_o !== 7'h03) begin failures++; $display("FAIL redir_older_id got=%0h exp=03", ifc.redirectAlID_o); end
    checks++; if (ifc.redirectPC_o !== 32'h300) begin failures++; $display("FAIL redir_older_pc got=%0h exp=300", ifc.redirectPC_o); end

    $display("txn redirect: younger mispredict id=0x07 target=0x700");
    exe(1'b1, 1'b1, 1'b1, 7'h07, 32'h6F0, 32'h700);
    tick(); clear_inputs();
    checks++; if (ifc.redirectAlID_o !== 7'h03) begin failures++; $display("FAIL redir_younger_id got=%0h exp=03", ifc.redirectAlID_o); end
    checks++; if (ifc.redirectPC_o !== 32'h300) begin failures++; $display("FAIL redir_younger_pc got=%0h exp=300", ifc.redirectPC_o); end

    $display("txn redirect: ack");
    ifc.redirectAck_i = 1'b1;
    tick(); clear_inputs();
    checks++; if (ifc.redirectValid_o !== 1'b0) begin failures++; $display("FAIL redir_ack got=%0h exp=0", ifc.redirectValid_o); end

    $display("txn redirect: wrap case held 0x3E new 0x41");
    exe(1'b1, 1'b1, 1'b1, 7'h3E, 32'h3E0, 32'h3F0);
    tick(); clear_inputs();
    exe(1'b1, 1'b1, 1'b1, 7'h41, 32'h400, 32'h410);
    tick(); clear_inputs();
    checks++; if (ifc.redirectAlID_o !== 7'h3E) begin failures++; $display("FAIL redir_wrap_id got=%0h exp=3e", ifc.redirectAlID_o); end
    checks++; if (ifc.redirectPC_o !== 32'h3F0) begin failures++; $display("FAIL redir_wrap_pc got=%0h exp=3f0", ifc.redirectPC_o); end

    $display("txn redirect: ack with same-cycle older mispredict id=0x3C");
    exe(1'b1, 1'b1, 1'b1, 7'h3C, 32'h3B0, 32'h3C0);
    ifc.redirectAck_i = 1'b1;
    tick(); clear_inputs();
    checks++; if (ifc.redirectValid_o !== 1'b1) begin failures++; $display("FAIL redir_ackold_valid got=%0h exp=1", ifc.redirectValid_o); end
    checks++; if (ifc.redirectAlID_o !== 7'h3C) begin failures++; $display("FAIL redir_ackold_id got=%0h exp=3c", ifc.redirectAlID_o); end
    checks++; if (ifc.redirectPC_o !== 32'h3C0) begin failures++; $display("FAIL redir_ackold_pc got=%0h exp=3c0", ifc.redirectPC_o); end

    $display("txn redirect: flush while held");
    ifc.flush_i = 1'b1;
    tick(); clear_inputs();
    checks++; if (ifc.redirectValid_o !== 1'b0) begin failures++; $display("FAIL redir_flush got=%0h exp=0", ifc.redirectValid_o); end
  endtask

  task automatic test_csr();
    $display("txn csr: CSRRW addr=0x001 data=0xA5 id=0x10");
    csr_req(12'h001, 32'hA5, 7'h10);
    tick(); clear_inputs();
    checks++; if (ifc.stall_o !== 1'b1) begin failures++; $display("FAIL csr_stall got=%0h exp=1", ifc.stall_o); end
    checks++; if (ifc.csrWrEn_o !== 1'b0) begin failures++; $display("FAIL csr_early_wr got=%0h exp=0", ifc.csrWrEn_o); end

    $display("txn csr: commit of unrelated id=0x11");
    ifc.commitValid_i = 1'b1;
    ifc.commitAlID_i  = 7'h11;
    tick(); clear_inputs();
    checks++; if (ifc.stall_o !== 1'b1) begin failures++; $display("FAIL csr_other_stall got=%0h exp=1", ifc.stall_o); end
    checks++; if (ifc.csrWrEn_o !== 1'b0) begin failures++; $display("FAIL csr_other_wr got=%0h exp=0", ifc.csrWrEn_o); end

    $display("txn csr: commit id=0x10");
    ifc.commitValid_i = 1'b1;
    ifc.commitAlID_i  = 7'h10;
    tick(); clear_inputs();
    checks++; if (ifc.csrWrEn_o !== 1'b1) begin failures++; $display("FAIL csr_wr got=%0h exp=1", ifc.csrWrEn_o); end
    checks++; if (ifc.csrWrAddr_o !== 12'h001) begin failures++; $display("FAIL csr_addr got=%0h exp=001", ifc.csrWrAddr_o); end
    checks++; if (ifc.csrWrData_o !== 32'hA5) begin failures++; $display("FAIL csr_data got=%0h exp=a5", ifc.csrWrData_o); end
    checks++; if (ifc.stall_o !== 1'b0) begin failures++; $display("FAIL csr_unstall got=%0h exp=0", ifc.stall_o); end
    tick();
    checks++; if (ifc.csrWrEn_o !== 1'b0) begin failures++; $display("FAIL csr_pulse_len got=%0h exp=0", ifc.csrWrEn_o); end
  endtask

  task automatic test_csr_flush();
    $display("txn csr_flush: buffer id=0x12 then flush");
    csr_req(12'h002, 32'h5A, 7'h12);
    tick(); clear_inputs();
    checks++; if (ifc.stall_o !== 1'b1) begin failures++; $display("FAIL csrf_stall got=%0h exp=1", ifc.stall_o); end
    ifc.flush_i = 1'b1;
    tick(); clear_inputs();
    checks++; if (ifc.stall_o !== 1'b0) begin failures++; $display("FAIL csrf_idle got=%0h exp=0", ifc.stall_o); end
    checks++; if (ifc.csrWrEn_o !== 1'b0) begin failures++; $display("FAIL csrf_nowr0 got=%0h exp=0", ifc.csrWrEn_o); end
    tick();
    checks++; if (ifc.csrWrEn_o !== 1'b0) begin failures++; $display("FAIL csrf_nowr1 got=%0h exp=0", ifc.csrWrEn_o); end

    $display("txn csr_flush: buffer id=0x13 then flush with same-cycle commit");
    csr_req(12'h003, 32'h77, 7'h13);
    tick(); clear_inputs();
    ifc.flush_i       = 1'b1;
    ifc.commitValid_i = 1'b1;
    ifc.commitAlID_i  = 7'h13;
    tick(); clear_inputs();
    checks++; if (ifc.csrWrEn_o !== 1'b1) begin failures++; $display("FAIL csrf_commit_wr got=%0h exp=1", ifc.csrWrEn_o); end
    checks++; if (ifc.csrWrAddr_o !== 12'h003) begin failures++; $display("FAIL csrf_commit_addr got=%0h exp=003", ifc.csrWrAddr_o); end
    checks++; if (ifc.csrWrData_o !== 32'h77) begin failures++; $display("FAIL csrf_commit_data got=%0h exp=77", ifc.csrWrData_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    $display("txn reset_mid: mispredict+CSR id=0x20, then async reset");
    exe(1'b1, 1'b1, 1'b1, 7'h20, 32'h4F0, 32'h500);
    ifc.csrWrEn_i   = 1'b1;
    ifc.csrWrAddr_i = 12'h004;
    ifc.csrWrData_i = 32'h99;
    tick(); clear_inputs();
    checks++; if (ifc.redirectValid_o !== 1'b1) begin failures++; $display("FAIL rm_held got=%0h exp=1", ifc.redirectValid_o); end
    checks++; if (ifc.stall_o !== 1'b1) begin failures++; $display("FAIL rm_pending got=%0h exp=1", ifc.stall_o); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (ifc.redirectValid_o !== 1'b0) begin failures++; $display("FAIL rm_redir got=%0h exp=0", ifc.redirectValid_o); end
    checks++; if (ifc.redirectPC_o !== '0) begin failures++; $display("FAIL rm_redir_pc got=%0h exp=0", ifc.redirectPC_o); end
    checks++; if (ifc.stall_o !== 1'b0) begin failures++; $display("FAIL rm_stall got=%0h exp=0", ifc.stall_o); end
    checks++; if (ifc.wbValid_o !== 1'b0) begin failures++; $display("FAIL rm_wb got=%0h exp=0", ifc.wbValid_o); end
    checks++; if (ifc.bpUpdValid_o !== 1'b0) begin failures++; $display("FAIL rm_bp got=%0h exp=0", ifc.bpUpdValid_o); end
    tick();
    reset_n = 1'b1;
    ifc.commitValid_i = 1'b1;
    ifc.commitAlID_i  = 7'h20;
    tick(); clear_inputs();
    checks++; if (ifc.csrWrEn_o !== 1'b0) begin failures++; $display("FAIL rm_nowr0 got=%0h exp=0", ifc.csrWrEn_o); end
    tick();
    checks++; if (ifc.csrWrEn_o !== 1'b0) begin failures++; $display("FAIL rm_nowr1 got=%0h exp=0", ifc.csrWrEn_o); end
    checks++; if (ifc.stall_o !== 1'b0) begin failures++; $display("FAIL rm_idle got=%0h exp=0", ifc.stall_o); end
  endtask

`ifdef CTRL_RESOLVE_PERF_EN
  task automatic test_perf();
    $display("txn perf: 3 predicted branches, 1 mispredict");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (perf_branch !== 32'd0) begin failures++; $display("FAIL perf_reset got=%0d exp=0", perf_branch); end
    exe(1'b0, 1'b1, 1'b1, 7'h01, 32'h10, 32'h20);
    tick();
    exe(1'b1, 1'b1, 1'b1, 7'h02, 32'h20, 32'h80);
    tick();
    exe(1'b0, 1'b1, 1'b1, 7'h03, 32'h30, 32'h40);
    tick(); clear_inputs();
    ifc.redirectAck_i = 1'b1;
    tick(); clear_inputs();
    checks++; if (perf_branch !== 32'd3) begin failures++; $display("FAIL perf_branch got=%0d exp=3", perf_branch); end
    checks++; if (perf_mispred !== 32'd1) begin failures++; $display("FAIL perf_mispred got=%0d exp=1", perf_mispred); end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_writeback();
    test_redirect();
    test_csr();
    test_csr_flush();
    test_reset_mid();
`ifdef CTRL_RESOLVE_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
